// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32 x 64-bit register file. It merges pipeline
// writeback with the NIC load-return path and tracks loads in flight so that
// decode can stall on registers whose data has not landed yet.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no load is being held off
//   COUNT | a valid load has been blocked; counting consecutive blocked cycles
//   STALL | load starved for STARVE_LIMIT cycles; wb_stall asserted
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [63:0] ld_data,
    output logic        ld_ready,
    input  logic        pend_set,
    input  logic [4:0]  pend_rd,
    input  logic [4:0]  rA,
    input  logic [4:0]  rB,
    output logic        rA_busy,
    output logic        rB_busy,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_rd_q, rf_rd_d;
    logic [63:0] rf_data_q, rf_data_d;
    logic        src_ld_q, src_ld_d;
    logic [31:0] pending_q, pending_d;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wb_stall_q, wb_stall_d;

    logic        ld_accept;
    logic        ld_blocked;
    logic [3:0]  cnt_inc;

    // Writeback always wins; loads are only taken on cycles without one.
    assign ld_ready   = reset & ~wb_valid;
    assign ld_accept  = ld_valid & ld_ready;
    assign ld_blocked = ld_valid & ~ld_ready;
    assign cnt_inc    = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

    assign rA_busy  = pending_q[rA];
    assign rB_busy  = pending_q[rB];
    assign wb_stall = wb_stall_q;
    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_data  = rf_data_q;

    // Select the granted request for the write stage; r0 is never written.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        src_ld_d  = 1'b0;
        if (wb_valid) begin
            rf_we_d   = (wb_rd != 5'd0);
            rf_rd_d   = wb_rd;
            rf_data_d = wb_data;
        end else if (ld_accept) begin
            rf_we_d   = (ld_rd != 5'd0);
            rf_rd_d   = ld_rd;
            rf_data_d = ld_data;
            src_ld_d  = 1'b1;
        end
    end

    // Pending-load scoreboard: clear as the load data is written, set wins.
    always_comb begin
        pending_d = pending_q;
        if (rf_we_q && src_ld_q) begin
            pending_d[rf_rd_q] = 1'b0;
        end
        if (pend_set && (pend_rd != 5'd0)) begin
            pending_d[pend_rd] = 1'b1;
        end
    end

    // Starvation tracking; the counter reaching the limit on this edge enters STALL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ld_blocked) begin
                    state_d = COUNT;
                    cnt_d   = 4'd1;
                end
            end
            COUNT: begin
                if (!ld_valid || ld_accept) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= LIMIT) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!ld_valid || ld_accept) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        wb_stall_d = (state_d == STALL);
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_data_q  <= 64'd0;
            src_ld_q   <= 1'b0;
            pending_q  <= 32'd0;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wb_stall_q <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
            src_ld_q   <= src_ld_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_stall_q <= wb_stall_d;
        end
    end

endmodule
